// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Multi-cycle fetch stage that owns the PC, issues one word request
//            at a time over req/ack and hands words to decode over valid/ready.
// Options  : FETCH_PERF_COUNTERS_EN adds perf_fetched / perf_stall_cycles.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        instr_valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    logic w_slot_free;
    logic w_load;
    logic w_consume;

    assign w_slot_free = !instr_valid_q || instr_ready;
    assign w_load      = (state_q == S_FETCH) && imem_ack && !redirect_valid;
    assign w_consume   = instr_valid_q && instr_ready && !w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
        end else if (redirect_valid) begin
            // Redirect flushes the slot; an in-flight request must still be
            // completed (DRAIN) because the memory owes us one ack.
            pc_q          <= redirect_pc & c_WORD_MASK;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            case (state_q)
                S_FETCH, S_DRAIN: begin
                    if (imem_ack) begin
                        state_q    <= S_IDLE;
                        imem_req_q <= 1'b0;
                    end else begin
                        state_q    <= S_DRAIN;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end else begin
            if (w_consume) begin
                instr_valid_q <= 1'b0;
                instr_q       <= NOP_INSTR;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_slot_free) begin
                        state_q     <= S_FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= imem_addr_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_q + c_PC_STEP;
                        state_q       <= S_IDLE;
                        imem_req_q    <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        state_q    <= S_IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= 32'h0;
            perf_stall_q   <= 32'h0;
        end else begin
            if (w_load) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (imem_req_q && !imem_ack) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

    assign imem_req       = imem_req_q;
    assign imem_addr      = imem_addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + c_PC_STEP;

endmodule
`default_nettype wire
